// File: rtl/cov_estimator.sv
// Windowed 4x4 sample covariance of Q4.12 return vectors, computed with one
// time-multiplexed 16x16 signed multiplier and published through valid/ack.
module cov_estimator #(
    parameter int LOG_N = 2,
    parameter int W     = 16
) (
    input  logic                    clk_100mhz,
    input  logic                    reset,
    input  logic                    ret_valid,
    output logic                    ret_ready,
    input  logic [0:3][W-1:0]       ret,
    output logic [0:3][0:3][W-1:0]  cov,
    output logic                    cov_valid,
    input  logic                    cov_ack,
    output logic                    overrun
);
    localparam int SW    = W + LOG_N;
    localparam int PW    = 2 * W + LOG_N;
    localparam int NPAIR = 10;
    localparam logic [LOG_N:0] LAST_CNT = (LOG_N + 1)'((1 << LOG_N) - 1);

    typedef enum logic [1:0] {IDLE, MAC, FIN, PUB} state_t;

    // Upper-triangle pair walked by both MAC and FIN: k -> (i, j).
    function automatic logic [1:0] pair_i(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2, 4'd3: return 2'd0;
            4'd4, 4'd5, 4'd6:       return 2'd1;
            4'd7, 4'd8:             return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] pair_j(input logic [3:0] k);
        case (k)
            4'd0:             return 2'd0;
            4'd1, 4'd4:       return 2'd1;
            4'd2, 4'd5, 4'd7: return 2'd2;
            default:          return 2'd3;
        endcase
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_k;
    logic [LOG_N:0]        r_cnt;
    logic signed [W-1:0]   r_x   [0:3];
    logic signed [SW-1:0]  r_s   [0:3];
    logic signed [PW-1:0]  r_p   [0:NPAIR-1];
    logic [W-1:0]          r_buf [0:NPAIR-1];

    logic [1:0]            w_i;
    logic [1:0]            w_j;
    logic                  w_last_k;
    logic                  w_accept;
    logic signed [W-1:0]   w_mi;
    logic signed [W-1:0]   w_mj;
    logic signed [W-1:0]   w_mul_a;
    logic signed [W-1:0]   w_mul_b;
    logic signed [2*W-1:0] w_prod;
    logic signed [PW-1:0]  w_prod_ext;
    logic signed [PW-1:0]  w_c;
    logic signed [PW-1:0]  w_r;
    logic [PW-W:0]         w_hi;
    logic [W-1:0]          w_sat;

    assign w_i      = pair_i(r_k);
    assign w_j      = pair_j(r_k);
    assign w_last_k = (r_k == 4'd9);
    assign w_accept = ret_valid && ret_ready;

    // The single multiplier squares samples in MAC and multiplies means in FIN.
    assign w_mi       = W'(r_s[w_i] >>> LOG_N);
    assign w_mj       = W'(r_s[w_j] >>> LOG_N);
    assign w_mul_a    = (r_state == FIN) ? w_mi : r_x[w_i];
    assign w_mul_b    = (r_state == FIN) ? w_mj : r_x[w_j];
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_prod_ext = {{LOG_N{w_prod[2*W-1]}}, w_prod};

    assign w_c  = (r_p[r_k] >>> LOG_N) - w_prod_ext;
    assign w_r  = w_c >>> 12;
    assign w_hi = w_r[PW-1:W-1];
    assign w_sat = (w_hi == '0 || w_hi == '1) ? w_r[W-1:0]
                 : (w_r[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

    always_ff @(posedge clk_100mhz) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_next    = r_state;
        ret_ready = 1'b0;
        case (r_state)
            IDLE: begin
                ret_ready = 1'b1;
                if (ret_valid) w_next = MAC;
            end
            MAC:     if (w_last_k) w_next = (r_cnt == LAST_CNT) ? FIN : IDLE;
            FIN:     if (w_last_k) w_next = PUB;
            PUB:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        // NOTE: the accumulators are reset as well, so a mid-window reset discards the partial window.
        if (reset) begin
            r_k       <= '0;
            r_cnt     <= '0;
            cov       <= '0;
            cov_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                r_x[n] <= '0;
                r_s[n] <= '0;
            end
            for (int n = 0; n < NPAIR; n++) begin
                r_p[n]   <= '0;
                r_buf[n] <= '0;
            end
        end else begin
            r_k <= ((r_state == MAC || r_state == FIN) && !w_last_k) ? r_k + 4'd1 : 4'd0;

            if (w_accept) begin
                for (int n = 0; n < 4; n++) begin
                    r_x[n] <= ret[n];
                    r_s[n] <= r_s[n] + {{LOG_N{ret[n][W-1]}}, ret[n]};
                end
            end

            if (r_state == MAC) begin
                r_p[r_k] <= r_p[r_k] + w_prod_ext;
                if (w_last_k) r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == FIN) r_buf[r_k] <= w_sat;

            if (r_state == PUB) begin
                for (int n = 0; n < NPAIR; n++) begin
                    cov[pair_i(4'(n))][pair_j(4'(n))] <= r_buf[n];
                    cov[pair_j(4'(n))][pair_i(4'(n))] <= r_buf[n];
                    r_p[n] <= '0;
                end
                for (int n = 0; n < 4; n++) r_s[n] <= '0;
                r_cnt     <= '0;
                cov_valid <= 1'b1;
                if (cov_valid && !cov_ack) overrun <= 1'b1;
            end else if (cov_valid && cov_ack) begin
                cov_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cov_estimator.sv
// Directed bench for cov_estimator: hand-computed covariance matrices, latency,
// throughput, overrun/ack handshake and mid-window reset.
module tb_cov_estimator;
    localparam int W = 16;

    logic                   clk_100mhz = 1'b0;
    logic                   reset      = 1'b1;
    logic                   ret_valid  = 1'b0;
    logic                   cov_ack    = 1'b0;
    logic [0:3][W-1:0]      ret        = '0;
    logic                   ret_ready;
    logic [0:3][0:3][W-1:0] cov;
    logic                   cov_valid;
    logic                   overrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    cov_estimator #(.LOG_N(2), .W(W)) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .ret_valid  (ret_valid),
        .ret_ready  (ret_ready),
        .ret        (ret),
        .cov        (cov),
        .cov_valid  (cov_valid),
        .cov_ack    (cov_ack),
        .overrun    (overrun)
    );

    // Presents a vector and returns #1 after the edge that accepted it.
    task automatic send_vec(input logic [W-1:0] a0, a1, a2, a3);
        int n;
        n = 0;
        ret[0] = a0; ret[1] = a1; ret[2] = a2; ret[3] = a3;
        ret_valid = 1'b1;
        while (ret_ready !== 1'b1 && n < 50) begin
            @(posedge clk_100mhz); #1;
            n++;
        end
        if (n >= 50) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: ret_ready=%b, required 1", ret_ready);
        end
        @(posedge clk_100mhz); #1;
        ret_valid = 1'b0;
    endtask

    task automatic wait_cov(output int edges);
        edges = 0;
        while (cov_valid !== 1'b1 && edges < 60) begin
            @(posedge clk_100mhz); #1;
            edges++;
        end
    endtask

    task automatic ack_cov();
        cov_ack = 1'b1;
        @(posedge clk_100mhz); #1;
        cov_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk_100mhz);
        #1 reset = 1'b0;
        n_vec++; if (ret_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, want 1", ret_ready); end
        n_vec++; if (cov_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, want 0", cov_valid); end
        n_vec++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL reset_overrun: got %b, want 0", overrun); end
        n_vec++; if (cov !== '0)         begin n_err++; $display("FAIL reset_cov: got %h, want 0", cov); end
    endtask

    task automatic test_ones_latency();
        int rise;
        bit ready_seen;
        rise = 0;
        ready_seen = 1'b0;
        repeat (4) send_vec(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk_100mhz); #1;
            if (e < 21 && ret_ready) ready_seen = 1'b1;
            if (cov_valid && rise == 0) rise = e;
        end
        n_vec++; if (rise != 21)      begin n_err++; $display("FAIL ones_latency: got %0d edges, want 21", rise); end
        n_vec++; if (ready_seen)      begin n_err++; $display("FAIL ones_ready_busy: ret_ready=1 seen, want 0 through MAC/FIN/PUB"); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (cov[i][j] !== 16'h0000) begin
                    n_err++; $display("FAIL ones_cov[%0d][%0d]: got %h, want 0000", i, j, cov[i][j]);
                end
            end
        ack_cov();
        n_vec++; if (cov_valid !== 1'b0) begin n_err++; $display("FAIL ones_ack: cov_valid=%b, want 0", cov_valid); end
    endtask

    task automatic test_asset0_var();
        logic [0:3][0:3][W-1:0] exp;
        int edges;
        exp = '0;
        exp[0][0] = 16'h1000;
        send_vec(16'h1000, 16'h0, 16'h0, 16'h0);
        send_vec(16'hF000, 16'h0, 16'h0, 16'h0);
        send_vec(16'h1000, 16'h0, 16'h0, 16'h0);
        send_vec(16'hF000, 16'h0, 16'h0, 16'h0);
        wait_cov(edges);
        n_vec++; if (edges >= 60) begin n_err++; $display("FAIL asset0_timeout: cov_valid=%b, want 1", cov_valid); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (cov[i][j] !== exp[i][j]) begin
                    n_err++; $display("FAIL asset0_cov[%0d][%0d]: got %h, want %h", i, j, cov[i][j], exp[i][j]);
                end
            end
        ack_cov();
    endtask

    task automatic test_pair_cov();
        logic [0:3][0:3][W-1:0] exp;
        int edges;
        exp = '0;
        exp[0][0] = 16'h0400; exp[0][1] = 16'h0400;
        exp[1][0] = 16'h0400; exp[1][1] = 16'h0400;
        send_vec(16'h0800, 16'h0800, 16'h0, 16'h0);
        send_vec(16'hF800, 16'hF800, 16'h0, 16'h0);
        send_vec(16'h0800, 16'h0800, 16'h0, 16'h0);
        send_vec(16'hF800, 16'hF800, 16'h0, 16'h0);
        wait_cov(edges);
        n_vec++; if (edges >= 60) begin n_err++; $display("FAIL pair_timeout: cov_valid=%b, want 1", cov_valid); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (cov[i][j] !== exp[i][j]) begin
                    n_err++; $display("FAIL pair_cov[%0d][%0d]: got %h, want %h", i, j, cov[i][j], exp[i][j]);
                end
            end
        ack_cov();
    endtask

    task automatic test_saturate();
        logic [0:3][0:3][W-1:0] exp;
        int edges;
        exp = '0;
        exp[0][0] = 16'h7FFF;
        send_vec(16'h7000, 16'h0, 16'h0, 16'h0);
        send_vec(16'h9000, 16'h0, 16'h0, 16'h0);
        send_vec(16'h7000, 16'h0, 16'h0, 16'h0);
        send_vec(16'h9000, 16'h0, 16'h0, 16'h0);
        wait_cov(edges);
        n_vec++; if (edges >= 60) begin n_err++; $display("FAIL sat_timeout: cov_valid=%b, want 1", cov_valid); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (cov[i][j] !== exp[i][j]) begin
                    n_err++; $display("FAIL sat_cov[%0d][%0d]: got %h, want %h", i, j, cov[i][j], exp[i][j]);
                end
            end
        ack_cov();
    endtask

    task automatic test_back_to_back();
        logic [0:3][W-1:0]      v [0:7];
        logic [0:3][0:3][W-1:0] exp;
        int acc [0:7];
        int n, cyc;
        v[0] = {16'h1000, 16'h0, 16'h0, 16'h0};
        v[1] = {16'hF000, 16'h0, 16'h0, 16'h0};
        v[2] = {16'h1000, 16'h0, 16'h0, 16'h0};
        v[3] = {16'hF000, 16'h0, 16'h0, 16'h0};
        v[4] = {16'h0800, 16'h0800, 16'h0, 16'h0};
        v[5] = {16'hF800, 16'hF800, 16'h0, 16'h0};
        v[6] = {16'h0800, 16'h0800, 16'h0, 16'h0};
        v[7] = {16'hF800, 16'hF800, 16'h0, 16'h0};
        exp = '0;
        exp[0][0] = 16'h0400; exp[0][1] = 16'h0400;
        exp[1][0] = 16'h0400; exp[1][1] = 16'h0400;
        for (int k = 0; k < 8; k++) acc[k] = 0;
        n = 0;
        cyc = 0;
        ret = v[0];
        ret_valid = 1'b1;
        while (n < 8 && cyc < 400) begin
            if (ret_ready) begin
                ret = v[n];
                acc[n] = cyc + 1;
                n++;
            end
            @(posedge clk_100mhz); #1;
            cyc++;
        end
        ret_valid = 1'b0;
        n_vec++; if (n != 8) begin n_err++; $display("FAIL b2b_accepts: got %0d, want 8", n); end
        for (int k = 1; k < 8; k++) begin
            n_vec++;
            if (k == 4) begin
                if (acc[4] - acc[3] != 22) begin
                    n_err++; $display("FAIL b2b_window_gap: got %0d cycles, want 22", acc[4] - acc[3]);
                end
            end else if (acc[k] - acc[k-1] != 11) begin
                n_err++; $display("FAIL b2b_interval[%0d]: got %0d cycles, want 11", k, acc[k] - acc[k-1]);
            end
        end
        n_vec++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL b2b_overrun_early: got %b, want 0", overrun); end
        n_vec++; if (cov_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_first: got %b, want 1", cov_valid); end
        repeat (21) @(posedge clk_100mhz);
        #1;
        n_vec++; if (overrun !== 1'b1)   begin n_err++; $display("FAIL b2b_overrun: got %b, want 1", overrun); end
        n_vec++; if (cov_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_second: got %b, want 1", cov_valid); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (cov[i][j] !== exp[i][j]) begin
                    n_err++; $display("FAIL b2b_cov[%0d][%0d]: got %h, want %h", i, j, cov[i][j], exp[i][j]);
                end
            end
        ack_cov();
        n_vec++; if (cov_valid !== 1'b0) begin n_err++; $display("FAIL b2b_ack: cov_valid=%b, want 0", cov_valid); end
        n_vec++; if (overrun !== 1'b1)   begin n_err++; $display("FAIL b2b_sticky: overrun=%b, want 1", overrun); end
    endtask

    task automatic test_mid_reset();
        logic [0:3][0:3][W-1:0] exp;
        int edges;
        exp = '0;
        exp[0][0] = 16'h1000;
        send_vec(16'h1000, 16'h0, 16'h0, 16'h0);
        send_vec(16'h1000, 16'h0, 16'h0, 16'h0);
        send_vec(16'h1000, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk_100mhz);
        #1 reset = 1'b1;
        @(posedge clk_100mhz);
        #1 reset = 1'b0;
        n_vec++; if (ret_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready: got %b, want 1", ret_ready); end
        n_vec++; if (cov_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid: got %b, want 0", cov_valid); end
        n_vec++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL mid_reset_overrun: got %b, want 0", overrun); end
        n_vec++; if (cov !== '0)         begin n_err++; $display("FAIL mid_reset_cov: got %h, want 0", cov); end
        send_vec(16'h1000, 16'h0, 16'h0, 16'h0);
        send_vec(16'hF000, 16'h0, 16'h0, 16'h0);
        send_vec(16'h1000, 16'h0, 16'h0, 16'h0);
        repeat (30) @(posedge clk_100mhz);
        #1;
        n_vec++; if (cov_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_early_pub: cov_valid=%b, want 0", cov_valid); end
        send_vec(16'hF000, 16'h0, 16'h0, 16'h0);
        wait_cov(edges);
        n_vec++; if (edges >= 60) begin n_err++; $display("FAIL mid_reset_timeout: cov_valid=%b, want 1", cov_valid); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (cov[i][j] !== exp[i][j]) begin
                    n_err++; $display("FAIL mid_reset_cov[%0d][%0d]: got %h, want %h", i, j, cov[i][j], exp[i][j]);
                end
            end
        ack_cov();
    endtask

    initial begin
        test_reset();
        test_ones_latency();
        test_asset0_var();
        test_pair_cov();
        test_saturate();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
